// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline sequencer.
package pipe_ctrl_pkg;
    typedef enum logic {RUN = 1'b0, MD_BUSY = 1'b1} state_e;
    localparam int MD_LAT_DEF = 4;
    localparam int REG_W = 5;
    localparam int MDC_W = 4;
endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// hazard_detect: flags a load in EX whose destination feeds the instruction in ID.
import pipe_ctrl_pkg::*;

module hazard_detect (
    input  logic             ex_memread_i,
    input  logic [REG_W-1:0] ex_rt_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic             id_uses_rt_i,
    output logic             load_use_o
);
    assign load_use_o = ex_memread_i && (ex_rt_i != '0) &&
                        ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: prioritised stall/flush control for the 5-stage pipeline plus stall counter.
import pipe_ctrl_pkg::*;

module pipe_ctrl #(
    parameter int MD_LAT = MD_LAT_DEF,
    parameter int CNT_W  = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic             id_uses_rt_i,
    input  logic             id_md_start_i,
    input  logic             ex_memread_i,
    input  logic [REG_W-1:0] ex_rt_i,
    input  logic             ex_branch_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    output logic             pc_we_o,
    output logic             if_id_we_o,
    output logic             id_ex_we_o,
    output logic             ex_mem_we_o,
    output logic             mem_wb_we_o,
    output logic             if_id_flush_o,
    output logic             id_ex_flush_o,
    output logic             ex_mem_flush_o,
    output logic             mem_wb_flush_o,
    output logic             md_busy_o,
    output logic [CNT_W-1:0] stall_cnt_o
);
    localparam logic [MDC_W-1:0] MD_LOAD = (MD_LAT > 1) ? MDC_W'(MD_LAT - 2) : '0;

    state_e           state_q, state_d;
    logic [MDC_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             load_use, mem_hold;

    hazard_detect u_hazard (
        .ex_memread_i (ex_memread_i),
        .ex_rt_i      (ex_rt_i),
        .id_rs_i      (id_rs_i),
        .id_rt_i      (id_rt_i),
        .id_uses_rt_i (id_uses_rt_i),
        .load_use_o   (load_use)
    );

    assign mem_hold = mem_req_i && !mem_ack_i;

    always_comb begin
        {pc_we_o, if_id_we_o, id_ex_we_o, ex_mem_we_o, mem_wb_we_o} = '1;
        {if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, mem_wb_flush_o} = '0;
        state_d = state_q;
        cnt_d   = cnt_q;
        if (mem_hold) begin
            {pc_we_o, if_id_we_o, id_ex_we_o, ex_mem_we_o} = '0;
            mem_wb_flush_o = 1'b1;
        end else if (state_q == MD_BUSY) begin
            {pc_we_o, if_id_we_o, id_ex_we_o} = '0;
            // the final busy cycle lets the mul/div result through to EX/MEM
            ex_mem_flush_o = (cnt_q != '0);
            cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
            state_d = (cnt_q != '0) ? MD_BUSY : RUN;
        end else if (ex_branch_taken_i) begin
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
        end else if (load_use) begin
            {pc_we_o, if_id_we_o} = '0;
            id_ex_flush_o = 1'b1;
        end else if (id_md_start_i && (MD_LAT > 1)) begin
            state_d = MD_BUSY;
            cnt_d   = MD_LOAD;
        end
        if (!rst_i) begin
            {pc_we_o, if_id_we_o, id_ex_we_o, ex_mem_we_o, mem_wb_we_o} = '0;
            {if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, mem_wb_flush_o} = '0;
        end
        stall_cnt_d = (!pc_we_o && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign md_busy_o   = (state_q == MD_BUSY);
    assign stall_cnt_o = stall_cnt_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and randomized checks of pipe_ctrl against a behavioural model.
module tb_pipe_ctrl;
    localparam int LAT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [4:0] rs, rt, ex_rt;
    logic       uses_rt, md, memread, br, req, ack;

    logic        pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
    logic        if_id_fl, id_ex_fl, ex_mem_fl, mem_wb_fl, md_busy;
    logic [15:0] stall;
    logic        s_pc_we, s_if_id_we, s_id_ex_we, s_ex_mem_we, s_mem_wb_we;
    logic        s_if_id_fl, s_id_ex_fl, s_ex_mem_fl, s_mem_wb_fl, s_md_busy;
    logic [3:0]  s_stall;

    pipe_ctrl #(.MD_LAT(LAT), .CNT_W(16)) u_dut (
        .clk_i(clk), .rst_i(rst_n), .id_rs_i(rs), .id_rt_i(rt), .id_uses_rt_i(uses_rt),
        .id_md_start_i(md), .ex_memread_i(memread), .ex_rt_i(ex_rt), .ex_branch_taken_i(br),
        .mem_req_i(req), .mem_ack_i(ack), .pc_we_o(pc_we), .if_id_we_o(if_id_we),
        .id_ex_we_o(id_ex_we), .ex_mem_we_o(ex_mem_we), .mem_wb_we_o(mem_wb_we),
        .if_id_flush_o(if_id_fl), .id_ex_flush_o(id_ex_fl), .ex_mem_flush_o(ex_mem_fl),
        .mem_wb_flush_o(mem_wb_fl), .md_busy_o(md_busy), .stall_cnt_o(stall)
    );

    pipe_ctrl #(.MD_LAT(LAT), .CNT_W(4)) u_sat (
        .clk_i(clk), .rst_i(rst_n), .id_rs_i(rs), .id_rt_i(rt), .id_uses_rt_i(uses_rt),
        .id_md_start_i(md), .ex_memread_i(memread), .ex_rt_i(ex_rt), .ex_branch_taken_i(br),
        .mem_req_i(req), .mem_ack_i(ack), .pc_we_o(s_pc_we), .if_id_we_o(s_if_id_we),
        .id_ex_we_o(s_id_ex_we), .ex_mem_we_o(s_ex_mem_we), .mem_wb_we_o(s_mem_wb_we),
        .if_id_flush_o(s_if_id_fl), .id_ex_flush_o(s_id_ex_fl), .ex_mem_flush_o(s_ex_mem_fl),
        .mem_wb_flush_o(s_mem_wb_fl), .md_busy_o(s_md_busy), .stall_cnt_o(s_stall)
    );

    wire [8:0] dut_vec = {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
                          if_id_fl, id_ex_fl, ex_mem_fl, mem_wb_fl};

    int       n_chk = 0, n_fail = 0;
    int       m_left = 0;
    int       m_stall = 0;
    logic [8:0] last_vec;
    logic     last_busy;

    function automatic logic model_lu();
        return memread && ex_rt != 0 && (ex_rt == rs || (uses_rt && ex_rt == rt));
    endfunction

    // {pc, if_id, id_ex, ex_mem, mem_wb we ; if_id, id_ex, ex_mem, mem_wb flush}
    function automatic logic [8:0] model_vec();
        if (!rst_n) return 9'b00000_0000;
        if (req && !ack) return 9'b00001_0001;
        if (m_left > 0) return (m_left > 1) ? 9'b00011_0010 : 9'b00011_0000;
        if (br) return 9'b11111_1100;
        if (model_lu()) return 9'b00111_0100;
        return 9'b11111_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic [4:0] a_rs, input logic [4:0] a_rt, input logic [4:0] a_ex_rt,
                        input logic a_uses, input logic a_md, input logic a_memread,
                        input logic a_br, input logic a_req, input logic a_ack);
        logic [8:0] e;
        logic lu;
        rs = a_rs; rt = a_rt; ex_rt = a_ex_rt; uses_rt = a_uses; md = a_md;
        memread = a_memread; br = a_br; req = a_req; ack = a_ack;
        @(negedge clk);
        e  = model_vec();
        lu = model_lu();
        last_vec  = dut_vec;
        last_busy = md_busy;
        chk("outputs", {23'd0, dut_vec}, {23'd0, e});
        chk("md_busy", {31'd0, md_busy}, {31'd0, m_left > 0});
        chk("stall_cnt", {16'd0, stall}, (m_stall > 65535) ? 65535 : m_stall);
        chk("stall_cnt_sat", {28'd0, s_stall}, (m_stall > 15) ? 15 : m_stall);
        @(posedge clk);
        if (rst_n) begin
            if (!e[8]) m_stall++;
            if (!(a_req && !a_ack)) begin
                if (m_left > 0) m_left--;
                else if (!a_br && !lu && a_md && LAT > 1) m_left = LAT - 1;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int nb, nf, nh;
        rst_n = 1'b0;
        rs = 0; rt = 0; ex_rt = 0; uses_rt = 0; md = 0; memread = 0; br = 0; req = 0; ack = 0;
        #2;
        chk("reset_outputs", {23'd0, dut_vec}, 0);
        chk("reset_busy", {31'd0, md_busy}, 0);
        chk("reset_stall", {16'd0, stall}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        step(8, 0, 8, 0, 0, 1, 0, 0, 0);
        chk("lu_pc_we", {31'd0, last_vec[8]}, 0);
        chk("lu_if_id_we", {31'd0, last_vec[7]}, 0);
        chk("lu_id_ex_flush", {31'd0, last_vec[2]}, 1);
        repeat (19) step(8, 0, 8, 0, 0, 1, 0, 0, 0);
        idle(1);
        chk("stall_after_20", {16'd0, stall}, 20);
        chk("stall_saturated", {28'd0, s_stall}, 15);

        step(0, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("rt0_no_stall", {31'd0, last_vec[8]}, 1);
        step(8, 0, 8, 0, 0, 1, 1, 0, 0);
        chk("branch_lu_vec", {23'd0, last_vec}, 9'b11111_1100);
        idle(1);
        chk("branch_lu_stall", {16'd0, stall}, 20);

        step(0, 0, 0, 0, 1, 0, 0, 0, 0);
        nb = 0; nf = 0;
        for (int i = 0; i < 8; i++) begin
            idle(1);
            if (last_busy) nb++;
            if (last_busy && last_vec[1]) nf++;
        end
        chk("md_busy_cycles", nb, 3);
        chk("md_flush_cycles", nf, 2);
        chk("md_stall", {16'd0, stall}, 23);

        step(0, 0, 0, 0, 1, 0, 0, 0, 0);
        nb = 0; nh = 0;
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 0, 0, 0, 0, 0, (i >= 1 && i < 4), 0);
            if (last_busy) nb++;
            if (last_busy && last_vec[0]) nh++;
        end
        chk("md_hold_busy_cycles", nb, 6);
        chk("md_hold_wb_flush", nh, 3);

        step(0, 0, 0, 0, 1, 0, 0, 0, 0);
        idle(1);
        chk("pre_reset_busy", {31'd0, md_busy}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_busy", {31'd0, md_busy}, 0);
        chk("async_reset_outputs", {23'd0, dut_vec}, 0);
        m_left = 0; m_stall = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("post_reset_stall", {16'd0, stall}, 0);
        idle(1);
        chk("post_reset_run", {23'd0, last_vec}, 9'b11111_0000);

        for (int i = 0; i < 2000; i++)
            step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline sequencer for the 5-stage MIPS core. It drives the write-enable and flush (bubble-insert) controls of the PC and of the four inter-stage pipe registers: IF/ID, ID/EX, EX/MEM and MEM/WB. It resolves four hazard sources, in fixed priority:
- data-memory wait,
- multi-cycle mul/div occupancy of EX,
- taken-branch redirect,
- load-use.

It also keeps a saturating stall-cycle counter for performance measurement.

## Interface
Parameters:
- MD_LAT, 4, cycles a mul/div op occupies EX; legal range 1..16
- CNT_W, 16, width of stall-cycle counter

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  reset, asynchronous, active-low
- id_rs_i  in  5  rs field of instruction in ID
- id_rt_i  in  5  rt field of instruction in ID
- id_uses_rt_i  in  1  ID instruction reads rt
- id_md_start_i  in  1  ID instruction is a multi-cycle mul/div
- ex_memread_i  in  1  EX instruction is a load
- ex_rt_i  in  5  destination rt of EX instruction
- ex_branch_taken_i  in  1  branch in EX resolved taken
- mem_req_i  in  1  MEM stage has an active data-memory access
- mem_ack_i  in  1  data memory completes access this cycle
- pc_we_o, if_id_we_o, id_ex_we_o, ex_mem_we_o, mem_wb_we_o  out  1 each  register load enables
- if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, mem_wb_flush_o  out  1 each  load a bubble (all-zero control) when the matching we is 1
- md_busy_o  out  1  FSM in MD_BUSY
- stall_cnt_o  out  CNT_W  stalled cycles since reset, saturating

## Operation
- Outputs are Mealy outputs: a function of the registered state plus the current-cycle inputs.
- While rst_i is low, every we/flush output is 0.

Default (RUN, no hazard):
- All we = 1, all flush = 0.

Priority 1, mem_hold = mem_req_i & ~mem_ack_i:
- pc, IF/ID, ID/EX and EX/MEM we = 0.
- mem_wb_we = 1 and mem_wb_flush = 1.
- FSM state and MD counter hold.
- Lower-priority hazards are ignored this cycle.

Priority 2, state MD_BUSY:
- pc, IF/ID and ID/EX we = 0.
- ex_mem_flush = 1.
- MEM/WB runs normally.
- The counter decrements each cycle. At counter == 0 the next state is RUN, and this last MD_BUSY cycle has ex_mem_flush = 0, so the mul/div result enters EX/MEM.

Priority 3, ex_branch_taken_i in RUN:
- pc_we = 1 (target is loaded).
- if_id_flush = 1 and id_ex_flush = 1.
- id_md_start_i is ignored, because that instruction is being flushed.

Priority 4, load-use in RUN:
- Condition: ex_memread_i & ex_rt_i != 0 & (ex_rt_i == id_rs_i | (id_uses_rt_i & ex_rt_i == id_rt_i)).
- Action: pc_we = 0, if_id_we = 0, id_ex_flush = 1.
- id_md_start_i is ignored this cycle; it re-presents the next cycle.

MD issue:
- Condition: RUN, id_md_start_i, and none of priorities 1, 3, 4.
- The mul/div instruction loads into ID/EX normally.
- If MD_LAT > 1: next state MD_BUSY, counter loaded with MD_LAT-2.
- If MD_LAT == 1: the FSM stays in RUN.

FSM:
- States RUN and MD_BUSY; reset state RUN.
- md_busy_o = (state == MD_BUSY).

stall_cnt_o:
- Increments on any cycle where pc_we_o == 0.
- Saturates at all-ones; reset value 0.

## Timing
- Zero-latency control: a hazard visible at the inputs in cycle N gates the register updates at the edge ending cycle N.
- A mul/div op occupies EX for exactly MD_LAT cycles when no mem_hold occurs. Each mem_hold cycle extends this by one.
- mem_req_i & mem_ack_i in the same cycle is not a hold.
- Branch and load-use in the same cycle: branch wins, no stall.
- mem_hold in the same cycle as MD issue: the issue is deferred, the state stays RUN.
- Reset asserted mid-MD_BUSY: the state goes to RUN immediately (asynchronous) and the counter clears to 0.
- Reset values: state RUN, MD counter 0, stall_cnt_o 0, md_busy_o 0, all we/flush 0.

## Structure
- Package pipe_ctrl_pkg holds:
  - the state enum (RUN = 0, MD_BUSY = 1),
  - the default MD_LAT,
  - the register-index width constant (5).
- One sub-module: hazard_detect, purely combinational. It takes the ID/EX fields and outputs load_use. It is reused by the forwarding unit later.
- Top level holds the FSM, the MD counter, the priority mux and the stall counter.

## Test plan
- Load-use: ex_memread_i = 1, ex_rt_i = 8, id_rs_i = 8 → one cycle with pc_we = 0, if_id_we = 0, id_ex_flush = 1; ex_rt_i = 0 gives no stall.
- Branch + load-use together → if_id_flush = 1, id_ex_flush = 1, pc_we = 1; stall_cnt unchanged.
- MD_LAT = 4, id_md_start_i pulse → md_busy_o high for 3 cycles; ex_mem_flush = 1 on the first 2 of them and 0 on the 3rd; pc_we = 0 for 3 cycles.
- mem_req_i high with mem_ack_i low for 3 cycles during MD_BUSY → counter frozen, mem_wb_flush = 1 for 3 cycles, MD_BUSY lasts 6 cycles total.
- Reset asserted while MD_BUSY → md_busy_o = 0 and all outputs 0 with no clock edge; after release, RUN with stall_cnt_o = 0.
- Force CNT_W = 4 with 20 stall cycles → stall_cnt_o saturates at 15.
